spi_master_byte_sequencer: RTL and testbench
============================================

Name: spi_master_byte_sequencer

Overview:
- Upstream feeder for the single-CS SPI master (SPI_Master_MaquinaEstats_MLF).
- Buffers host TX bytes in a FIFO and issues a multi-byte CS transaction byte by byte over the master's TX_DV/TX_Ready handshake.
- Collects each returned RX byte into an RX FIFO and signals completion, so the host never handles per-byte SPI timing.

Parameters:
- MAX_BYTES_PER_CS, 2, max bytes per CS transaction; must match the master.
- FIFO_DEPTH, 4, entries in each of the TX and RX FIFOs; power of two, >= MAX_BYTES_PER_CS.

Ports:
- i_clk  in  1  system clock; all logic on rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_wr_byte  in  8  host byte to enqueue for transmit.
- i_wr_en  in  1  push i_wr_byte into the TX FIFO.
- o_tx_full  out  1  TX FIFO full.
- o_tx_level  out  $clog2(FIFO_DEPTH+1)  TX FIFO occupancy.
- i_start  in  1  start-transaction request pulse.
- i_len  in  $clog2(MAX_BYTES_PER_CS+1)  bytes in the transaction.
- o_busy  out  1  transaction in progress.
- o_done  out  1  one-cycle pulse, transaction complete.
- o_err  out  1  one-cycle pulse, start rejected or write dropped.
- o_rx_byte  out  8  RX FIFO head, first-word-fall-through.
- o_rx_empty  out  1  RX FIFO empty.
- i_rx_rd  in  1  pop the RX FIFO head.
- o_TX_count  out  $clog2(MAX_BYTES_PER_CS+1)  byte count presented to the master.
- o_TX_Byte  out  8  byte presented to the master.
- o_TX_DV  out  1  one-cycle data-valid to the master.
- i_TX_Ready  in  1  master ready for the next byte.
- i_RX_DV  in  1  master RX byte valid.
- i_RX_Byte  in  8  master RX byte.

Behaviour:
- Reset (i_rst=1 at an edge):
  - FIFOs emptied; FSM to IDLE.
  - o_TX_DV, o_done, o_err, o_busy = 0.
  - o_TX_count, o_TX_Byte = 0.
  - o_tx_full = 0, o_tx_level = 0, o_rx_empty = 1.
  - Reset mid-transaction drops all state. A later i_RX_DV from the master is discarded.
- TX FIFO writes:
  - i_wr_en while not full pushes the byte; level updates next cycle.
  - i_wr_en while full drops the byte and pulses o_err.
  - Writes are accepted in every state, including during a transaction.
- RX FIFO reads:
  - i_rx_rd while empty is ignored.
  - A push and a pop in the same cycle both take effect.
- FSM states: IDLE, ISSUE, WAIT_RX, DONE.
- IDLE, on i_start:
  - Accept only if 1 <= i_len <= MAX_BYTES_PER_CS, TX level >= i_len, and RX free entries >= i_len.
  - On accept: latch i_len into o_TX_count, clear the byte counter, set o_busy, go to ISSUE.
  - On reject: pulse o_err for one cycle and stay in IDLE.
  - i_start outside IDLE is ignored, with no o_err.
- ISSUE:
  - Wait for i_TX_Ready=1.
  - In that cycle pop the TX head, register it onto o_TX_Byte, assert o_TX_DV for exactly one cycle, then go to WAIT_RX.
  - o_TX_Byte holds its value until the next issue.
- WAIT_RX:
  - i_TX_Ready is ignored.
  - On i_RX_DV, push i_RX_Byte into the RX FIFO and increment the counter.
  - If counter+1 == latched len go to DONE, else go to ISSUE.
  - Back-to-back bytes stay within one CS; the master keeps CS low because o_TX_count is held constant.
- DONE: one-cycle o_done pulse, clear o_busy, go to IDLE.
- Latency:
  - i_start accept to first o_TX_DV is 1 cycle if i_TX_Ready is already high.
  - Final i_RX_DV to o_done is 1 cycle.
- i_RX_DV in IDLE, ISSUE or DONE is discarded.
- RX overflow cannot occur, because free space is reserved at start.
- Pointers wrap modulo FIFO_DEPTH; levels saturate at 0 and FIFO_DEPTH.

Optional Feature:
SPI_SEQ_LOOPBACK_CHECK_EN:
- When defined:
  - Adds output o_mismatch (1 bit).
  - Each issued byte is stored; on the matching i_RX_DV, i_RX_Byte is compared with it.
  - o_mismatch is sticky-set on inequality and cleared only by reset or an accepted i_start.
  - Used for MOSI->MISO loopback self-test.
- When undefined: the port and logic are absent, and behaviour is otherwise identical.

Test Plan:
- Reset held 10 cycles -> all outputs at reset values, o_rx_empty=1, o_tx_level=0.
- Write 0xFF, 0x88; i_start with i_len=2, master in loopback -> o_TX_count=2, exactly two o_TX_DV pulses carrying 0xFF then 0x88, one o_done; RX reads 0xFF then 0x88; o_tx_level=0.
- Write one byte; i_start with i_len=2 -> o_err pulse, no o_TX_DV, o_busy stays 0, o_tx_level=1.
- i_start with i_len=0, then with i_len=3 -> o_err pulse each time, FSM stays in IDLE.
- Five writes with FIFO_DEPTH=4 -> fifth write gives an o_err pulse, o_tx_full=1, o_tx_level=4.
- i_rst pulsed between the first and second o_TX_DV of a 2-byte transaction, followed by a late i_RX_DV -> no further o_TX_DV, RX FIFO empty, no o_done.
- With SPI_SEQ_LOOPBACK_CHECK_EN defined, send 0xA5 while the bench returns 0x5A -> o_mismatch=1, held until the next accepted start.

Source files
------------

// File: rtl/spi_master_byte_sequencer.sv
// Byte sequencer feeding a single-CS SPI master: TX/RX FIFOs and a per-byte handshake FSM.
// Optional define SPI_SEQ_LOOPBACK_CHECK_EN adds the o_mismatch loopback self-test output.
module spi_master_byte_sequencer #(
  parameter int unsigned MAX_BYTES_PER_CS = 2,
  parameter int unsigned FIFO_DEPTH       = 4,
  localparam int unsigned LW = $clog2(FIFO_DEPTH + 1),
  localparam int unsigned CW = $clog2(MAX_BYTES_PER_CS + 1),
  localparam int unsigned PW = $clog2(FIFO_DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [7:0]    i_wr_byte,
  input  logic          i_wr_en,
  output logic          o_tx_full,
  output logic [LW-1:0] o_tx_level,
  input  logic          i_start,
  input  logic [CW-1:0] i_len,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err,
  output logic [7:0]    o_rx_byte,
  output logic          o_rx_empty,
  input  logic          i_rx_rd,
`ifdef SPI_SEQ_LOOPBACK_CHECK_EN
  output logic          o_mismatch,
`endif
  output logic [CW-1:0] o_TX_count,
  output logic [7:0]    o_TX_Byte,
  output logic          o_TX_DV,
  input  logic          i_TX_Ready,
  input  logic          i_RX_DV,
  input  logic [7:0]    i_RX_Byte
);

  typedef enum logic [1:0] {StIdle, StIssue, StWaitRx, StDone} state_e;

  state_e state_q, state_d;

  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [PW-1:0] tx_wr_ptr_q, tx_rd_ptr_q, rx_wr_ptr_q, rx_rd_ptr_q;
  logic [LW-1:0] tx_level_q, rx_level_q;
  logic [CW-1:0] byte_cnt_q, count_q;
  logic [7:0]    tx_byte_q;
  logic          tx_dv_q, err_q;

  logic          tx_push, tx_pop, rx_push, rx_pop, wr_drop;
  logic          accept, reject, start_ok;
  logic [LW-1:0] len_ext;

  assign o_tx_full  = (tx_level_q == LW'(FIFO_DEPTH));
  assign o_tx_level = tx_level_q;
  assign o_rx_empty = (rx_level_q == '0);
  assign o_rx_byte  = rx_mem[rx_rd_ptr_q];
  assign o_TX_count = count_q;
  assign o_TX_Byte  = tx_byte_q;
  assign o_TX_DV    = tx_dv_q;
  assign o_err      = err_q;
  assign o_busy     = (state_q != StIdle);
  assign o_done     = (state_q == StDone);

  assign tx_push = i_wr_en && !o_tx_full;
  assign wr_drop = i_wr_en && o_tx_full;
  assign rx_pop  = i_rx_rd && !o_rx_empty;

  // RX space is reserved up front so an RX push can never overflow.
  assign len_ext  = LW'(i_len);
  assign start_ok = (i_len != '0) && (i_len <= CW'(MAX_BYTES_PER_CS)) &&
                    (tx_level_q >= len_ext) && ((LW'(FIFO_DEPTH) - rx_level_q) >= len_ext);

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    tx_pop  = 1'b0;
    rx_push = 1'b0;
    accept  = 1'b0;
    reject  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          if (start_ok) begin
            accept  = 1'b1;
            state_d = StIssue;
          end else begin
            reject = 1'b1;
          end
        end
      end
      StIssue: begin
        if (i_TX_Ready) begin
          tx_pop  = 1'b1;
          state_d = StWaitRx;
        end
      end
      StWaitRx: begin
        if (i_RX_DV) begin
          rx_push = 1'b1;
          state_d = (byte_cnt_q + CW'(1) == count_q) ? StDone : StIssue;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (tx_push) tx_mem[tx_wr_ptr_q] <= i_wr_byte;
    if (rx_push) rx_mem[rx_wr_ptr_q] <= i_RX_Byte;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      tx_level_q  <= '0;
      rx_level_q  <= '0;
      byte_cnt_q  <= '0;
      count_q     <= '0;
      tx_byte_q   <= '0;
      tx_dv_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      tx_dv_q <= tx_pop;
      err_q   <= wr_drop || reject;
      if (tx_pop) begin
        tx_byte_q   <= tx_mem[tx_rd_ptr_q];
        tx_rd_ptr_q <= tx_rd_ptr_q + PW'(1);
      end
      if (tx_push) tx_wr_ptr_q <= tx_wr_ptr_q + PW'(1);
      if (tx_push && !tx_pop)      tx_level_q <= tx_level_q + LW'(1);
      else if (tx_pop && !tx_push) tx_level_q <= tx_level_q - LW'(1);
      if (rx_push) rx_wr_ptr_q <= rx_wr_ptr_q + PW'(1);
      if (rx_pop)  rx_rd_ptr_q <= rx_rd_ptr_q + PW'(1);
      if (rx_push && !rx_pop)      rx_level_q <= rx_level_q + LW'(1);
      else if (rx_pop && !rx_push) rx_level_q <= rx_level_q - LW'(1);
      if (accept) begin
        count_q    <= i_len;
        byte_cnt_q <= '0;
      end else if (rx_push) begin
        byte_cnt_q <= byte_cnt_q + CW'(1);
      end
    end
  end

`ifdef SPI_SEQ_LOOPBACK_CHECK_EN
  logic mismatch_q;

  // tx_byte_q still holds the byte whose echo is arriving.
  always_ff @(posedge i_clk) begin
    if (i_rst || accept)                        mismatch_q <= 1'b0;
    else if (rx_push && i_RX_Byte != tx_byte_q) mismatch_q <= 1'b1;
  end

  assign o_mismatch = mismatch_q;
`endif

endmodule

// File: tb/tb_spi_master_byte_sequencer.sv
// Bench for spi_master_byte_sequencer: loopback master model, table of transactions,
// byte scoreboards, and hand sequences for full FIFO, mid-transaction reset and loopback check.
module tb_spi_master_byte_sequencer;

  logic       clk = 1'b0;
  logic       i_rst = 1'b1;
  logic [7:0] i_wr_byte = '0;
  logic       i_wr_en = 1'b0;
  logic       o_tx_full;
  logic [2:0] o_tx_level;
  logic       i_start = 1'b0;
  logic [1:0] i_len = '0;
  logic       o_busy, o_done, o_err;
  logic [7:0] o_rx_byte;
  logic       o_rx_empty;
  logic       i_rx_rd = 1'b0;
  logic [1:0] o_TX_count;
  logic [7:0] o_TX_Byte;
  logic       o_TX_DV;
  logic       i_TX_Ready = 1'b1;
  logic       i_RX_DV = 1'b0;
  logic [7:0] i_RX_Byte = '0;
`ifdef SPI_SEQ_LOOPBACK_CHECK_EN
  logic       o_mismatch;
`endif

  always #5 clk = ~clk;

  spi_master_byte_sequencer #(.MAX_BYTES_PER_CS(2), .FIFO_DEPTH(4)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_wr_byte(i_wr_byte), .i_wr_en(i_wr_en),
    .o_tx_full(o_tx_full), .o_tx_level(o_tx_level), .i_start(i_start), .i_len(i_len),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_rx_byte(o_rx_byte),
    .o_rx_empty(o_rx_empty), .i_rx_rd(i_rx_rd),
`ifdef SPI_SEQ_LOOPBACK_CHECK_EN
    .o_mismatch(o_mismatch),
`endif
    .o_TX_count(o_TX_count), .o_TX_Byte(o_TX_Byte), .o_TX_DV(o_TX_DV),
    .i_TX_Ready(i_TX_Ready), .i_RX_DV(i_RX_DV), .i_RX_Byte(i_RX_Byte)
  );

  int n_vec = 0, n_bad = 0;
  int dv_cnt = 0, done_cnt = 0, err_cnt = 0, tick_no = 0;
  int first_dv_tick = -1, last_rxdv_tick = 0, done_tick = 0;
  int mst_cnt = 0;
  logic [7:0] mst_pend = '0;
  logic [7:0] rx_xor = '0;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];

  typedef struct {
    int         nw;
    logic [7:0] w0;
    logic [7:0] w1;
    int         len;
    bit         acc;
    int         lvl;
  } vec_t;
  vec_t vt[8];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // One clock: sample just after the edge, then run the master model and scoreboard.
  task automatic tick();
    logic [7:0] exp;
    @(posedge clk);
    #1;
    tick_no++;
    i_RX_DV = 1'b0;
    if (o_done) begin
      done_cnt++;
      done_tick = tick_no;
    end
    if (o_err) err_cnt++;
    if (o_TX_DV) begin
      dv_cnt++;
      if (first_dv_tick < 0) first_dv_tick = tick_no;
      if (tx_q.size() == 0) begin
        check("tx_dv_unexpected", o_TX_DV, 0);
      end else begin
        exp = tx_q.pop_front();
        check("tx_byte", o_TX_Byte, exp);
        rx_q.push_back(exp ^ rx_xor);
      end
      mst_pend   = o_TX_Byte;
      mst_cnt    = 3;
      i_TX_Ready = 1'b0;
    end else if (mst_cnt > 0) begin
      mst_cnt--;
      if (mst_cnt == 0) begin
        i_RX_DV        = 1'b1;
        i_RX_Byte      = mst_pend ^ rx_xor;
        i_TX_Ready     = 1'b1;
        last_rxdv_tick = tick_no;
      end
    end
  endtask

  task automatic write_byte(input logic [7:0] b, input bit expect_kept);
    i_wr_en   = 1'b1;
    i_wr_byte = b;
    if (expect_kept) tx_q.push_back(b);
    tick();
    i_wr_en = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int k = 0; k < budget && done_cnt == 0; k++) tick();
    if (done_cnt == 0) check("done_timeout", done_cnt, 1);
  endtask

  task automatic do_start(input int len, input bit acc, input int lvl);
    int s;
    dv_cnt = 0;
    done_cnt = 0;
    err_cnt = 0;
    first_dv_tick = -1;
    i_start = 1'b1;
    i_len   = len[1:0];
    tick();
    i_start = 1'b0;
    s = tick_no;
    check("busy_on_start", o_busy, acc);
    if (acc) begin
      wait_done(80);
      check("start_to_dv", first_dv_tick - s, 1);
      check("rxdv_to_done", done_tick - last_rxdv_tick, 1);
      check("dv_pulses", dv_cnt, len);
      check("tx_count", o_TX_count, len);
      tick();
      check("busy_clear", o_busy, 0);
      check("done_pulses", done_cnt, 1);
    end else begin
      repeat (4) tick();
      check("dv_on_reject", dv_cnt, 0);
      check("busy_on_reject", o_busy, 0);
    end
    check("err_pulses", err_cnt, acc ? 0 : 1);
    check("tx_level", o_tx_level, lvl);
  endtask

  task automatic drain_rx();
    while (rx_q.size() > 0) begin
      check("rx_not_empty", o_rx_empty, 0);
      check("rx_byte", o_rx_byte, rx_q.pop_front());
      i_rx_rd = 1'b1;
      tick();
      i_rx_rd = 1'b0;
    end
    check("rx_empty", o_rx_empty, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vt[0] = '{nw: 2, w0: 8'hFF, w1: 8'h88, len: 2, acc: 1, lvl: 0};
    vt[1] = '{nw: 1, w0: 8'h3C, w1: 8'h00, len: 1, acc: 1, lvl: 0};
    vt[2] = '{nw: 0, w0: 8'h00, w1: 8'h00, len: 0, acc: 0, lvl: 0};
    vt[3] = '{nw: 1, w0: 8'hA1, w1: 8'h00, len: 2, acc: 0, lvl: 1};
    vt[4] = '{nw: 0, w0: 8'h00, w1: 8'h00, len: 3, acc: 0, lvl: 1};
    vt[5] = '{nw: 1, w0: 8'hB2, w1: 8'h00, len: 2, acc: 1, lvl: 0};
    vt[6] = '{nw: 2, w0: 8'hC3, w1: 8'hD4, len: 1, acc: 1, lvl: 1};
    vt[7] = '{nw: 0, w0: 8'h00, w1: 8'h00, len: 1, acc: 1, lvl: 0};

    i_rst = 1'b1;
    repeat (10) tick();
    check("rst_tx_dv", o_TX_DV, 0);
    check("rst_done", o_done, 0);
    check("rst_err", o_err, 0);
    check("rst_busy", o_busy, 0);
    check("rst_tx_count", o_TX_count, 0);
    check("rst_tx_byte", o_TX_Byte, 0);
    check("rst_tx_full", o_tx_full, 0);
    check("rst_tx_level", o_tx_level, 0);
    check("rst_rx_empty", o_rx_empty, 1);
    i_rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      if (vt[i].nw > 0) write_byte(vt[i].w0, 1'b1);
      if (vt[i].nw > 1) write_byte(vt[i].w1, 1'b1);
      do_start(vt[i].len, vt[i].acc, vt[i].lvl);
      drain_rx();
    end

    // Fill the TX FIFO past its depth; the fifth byte must be dropped.
    err_cnt = 0;
    for (int k = 0; k < 4; k++) write_byte(8'h10 + 8'(k), 1'b1);
    check("full_after_4", o_tx_full, 1);
    check("level_after_4", o_tx_level, 4);
    check("err_after_4", err_cnt, 0);
    write_byte(8'h99, 1'b0);
    check("err_on_5th", err_cnt, 1);
    check("full_after_5", o_tx_full, 1);
    check("level_after_5", o_tx_level, 4);
    do_start(2, 1'b1, 2);
    drain_rx();
    do_start(2, 1'b1, 0);
    drain_rx();

    // Reset between the two issues of a 2-byte transaction; the late RX byte must vanish.
    write_byte(8'h5E, 1'b1);
    write_byte(8'h6F, 1'b1);
    dv_cnt = 0;
    i_start = 1'b1;
    i_len   = 2'd2;
    tick();
    i_start = 1'b0;
    for (int k = 0; k < 20 && dv_cnt == 0; k++) tick();
    check("rst_seq_first_dv", dv_cnt, 1);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    tx_q.delete();
    rx_q.delete();
    dv_cnt = 0;
    done_cnt = 0;
    repeat (10) tick();
    check("rst_seq_no_dv", dv_cnt, 0);
    check("rst_seq_no_done", done_cnt, 0);
    check("rst_seq_rx_empty", o_rx_empty, 1);
    check("rst_seq_busy", o_busy, 0);
    check("rst_seq_level", o_tx_level, 0);

`ifdef SPI_SEQ_LOOPBACK_CHECK_EN
    rx_xor = 8'hFF;
    write_byte(8'hA5, 1'b1);
    do_start(1, 1'b1, 0);
    check("mismatch_set", o_mismatch, 1);
    repeat (3) tick();
    check("mismatch_held", o_mismatch, 1);
    rx_xor = 8'h00;
    drain_rx();
    write_byte(8'h11, 1'b1);
    do_start(1, 1'b1, 0);
    check("mismatch_cleared", o_mismatch, 0);
    drain_rx();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
